// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: byte handshake between the store decode logic and the UART transmitter.
interface uart_transmitter_if;
    logic [7:0] DataIn;
    logic       DataInValid;
    logic       DataInReady;
    modport master (output DataIn, DataInValid, input DataInReady);
    modport slave (input DataIn, DataInValid, output DataInReady);
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises accepted bytes as 8N1 UART on SOut, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module uart_transmitter #(
    parameter int ClockFreq = 100_000_000,
    parameter int BaudRate  = 115_200
) (
    input  logic              Clock,
    input  logic              Reset_n,
    uart_transmitter_if.slave txIf,
    output logic              SOut
);
    localparam int CyclesPerBit = ClockFreq / BaudRate;
    localparam int CntW = $clog2(CyclesPerBit);
    localparam logic [CntW-1:0] LastCycle = CntW'(CyclesPerBit - 1);

    typedef enum logic [2:0] {
        Idle,
        Start,
        Data,
`ifdef UART_TX_PARITY_EN
        Parity,
`endif
        Stop
    } stateT;

    stateT           state, stateNext;
    logic [CntW-1:0] cycleCnt, cycleNext;
    logic [2:0]      bitCnt, bitNext;
    logic [7:0]      shiftReg, shiftNext;
    logic            sOutNext;
    logic            wrap;
`ifdef UART_TX_PARITY_EN
    logic            parityReg, parityNext;
`endif

    assign wrap = cycleCnt == LastCycle;
    assign txIf.DataInReady = state == Idle;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= Idle;
            cycleCnt <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            SOut     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parityReg <= 1'b0;
`endif
        end else begin
            state    <= stateNext;
            cycleCnt <= cycleNext;
            bitCnt   <= bitNext;
            shiftReg <= shiftNext;
            SOut     <= sOutNext;
`ifdef UART_TX_PARITY_EN
            parityReg <= parityNext;
`endif
        end
    end

    // SOut is registered from the next state so the line follows the state register exactly.
    always_comb begin
        stateNext = state;
        cycleNext = state == Idle ? '0 : wrap ? '0 : cycleCnt + 1'b1;
        bitNext   = bitCnt;
        shiftNext = shiftReg;
`ifdef UART_TX_PARITY_EN
        parityNext = parityReg;
`endif
        case (state)
            Idle: if (txIf.DataInValid) begin
                stateNext = Start;
                shiftNext = txIf.DataIn;
`ifdef UART_TX_PARITY_EN
                parityNext = ^txIf.DataIn;
`endif
            end
            Start: if (wrap) stateNext = Data;
            Data: if (wrap) begin
                shiftNext = shiftReg >> 1;
                bitNext   = bitCnt + 1'b1;
`ifdef UART_TX_PARITY_EN
                if (bitCnt == 3'd7) stateNext = Parity;
`else
                if (bitCnt == 3'd7) stateNext = Stop;
`endif
            end
`ifdef UART_TX_PARITY_EN
            Parity: if (wrap) stateNext = Stop;
`endif
            Stop: if (wrap) stateNext = Idle;
            default: stateNext = Idle;
        endcase
`ifdef UART_TX_PARITY_EN
        sOutNext = stateNext == Start ? 1'b0 : stateNext == Data ? shiftNext[0] :
                   stateNext == Parity ? parityNext : 1'b1;
`else
        sOutNext = stateNext == Start ? 1'b0 : stateNext == Data ? shiftNext[0] : 1'b1;
`endif
    end
endmodule
